// File: rtl/sdram_bus_pkg.sv
`default_nettype none
// =====================================================================
// sdram_bus_pkg : shared types and default timing for controller-bus
//                 responders (stub and future controller variants).
// Revision 1.0
// =====================================================================
package sdram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    REFRESH = 2'd3
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  localparam int DEF_ADDR_W     = 23;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_MEM_AW     = 10;
  localparam int DEF_LAT_WR     = 4;
  localparam int DEF_LAT_RD     = 6;
  localparam int DEF_REF_PERIOD = 390;
  localparam int DEF_REF_CYCLES = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..maxval, never less than one.
  function automatic int cnt_width(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_stub_mem.sv
`default_nettype none
// =====================================================================
// sdram_stub_mem : single-port synchronous RAM, registered read,
//                  written to map onto FPGA block RAM.
// Revision 1.0
// =====================================================================
module sdram_stub_mem
  import sdram_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Read register only moves on a read, so the last read word is held.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sdram_bus_stub.sv
`default_nettype none
// =====================================================================
// sdram_bus_stub : block-RAM responder on the SDRAM controller bus with
//                  programmable latency and periodic refresh stalls.
// Revision 1.0
// =====================================================================
module sdram_bus_stub
  import sdram_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_AW     = DEF_MEM_AW,
  parameter int LAT_WR     = DEF_LAT_WR,
  parameter int LAT_RD     = DEF_LAT_RD,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int REF_CYCLES = DEF_REF_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wrreq,
  input  logic              rereq,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rwdone,
  output logic              rw_wait,
  output logic              rw_busy,
  output logic              err
);

  localparam int CNT_W = cnt_width(max3(LAT_WR, LAT_RD, REF_CYCLES));
  // ACCESS lasts LAT-1 cycles so that rwdone lands LAT cycles after accept.
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(LAT_WR - 2);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(LAT_RD - 2);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  op_e                 op_q, op_d;
  logic [MEM_AW-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                rd_valid_q, rd_valid_d;

  logic                ref_pend;
  logic                ref_take;
  logic                mem_rd;
  logic                mem_wr;
  logic [CNT_W-1:0]    acc_last;
  logic [DATA_W-1:0]   mem_rdata;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_WR;
      maddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    ref_take   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    acc_last   = (op_q == OP_RD) ? RD_LAST : WR_LAST;

    case (state_q)
      IDLE: begin
        // Refresh wins; a held request is picked up once the stall ends.
        if (ref_pend) begin
          ref_take = 1'b1;
          cnt_d    = '0;
          state_d  = REFRESH;
        end else if (wrreq || rereq) begin
          state_d = ACCESS;
          cnt_d   = '0;
          op_d    = wrreq ? OP_WR : OP_RD;
          maddr_d = addr[MEM_AW-1:0];
          wdata_d = wdata;
          if (wrreq && rereq) begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == acc_last) begin
          state_d = DONE;
          if (op_q == OP_RD) begin
            mem_rd     = 1'b1;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        mem_wr  = (op_q == OP_WR);
      end
      REFRESH: begin
        if (cnt_q == REF_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if (REF_PERIOD > 0) begin : g_refresh
    localparam int RW = cnt_width(REF_PERIOD - 1);
    localparam logic [RW-1:0] REF_WRAP = RW'(REF_PERIOD - 1);

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic          pend_q, pend_d;
    logic          wrap;

    assign wrap      = (ref_cnt_q == REF_WRAP);
    assign ref_cnt_d = wrap ? '0 : ref_cnt_q + RW'(1);
    // A new wrap on the same edge as a refresh entry keeps the flag set.
    assign pend_d    = wrap | (pend_q & ~ref_take);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        ref_cnt_q <= '0;
        pend_q    <= 1'b0;
      end else begin
        ref_cnt_q <= ref_cnt_d;
        pend_q    <= pend_d;
      end
    end

    assign ref_pend = pend_q;
    assign rw_wait  = (state_q == REFRESH);
  end else begin : g_no_refresh
    assign ref_pend = 1'b0;
    assign rw_wait  = 1'b0;
  end

  if (ADDR_W > MEM_AW) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW];
  end

  sdram_stub_mem #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_mem (
    .clk     (CLOCK_50),
    .en_i    (mem_rd | mem_wr),
    .we_i    (mem_wr),
    .addr_i  (maddr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign rwdone  = (state_q == DONE);
  assign rw_busy = (state_q != IDLE);
  assign err     = err_q;
  assign rdata   = rd_valid_q ? mem_rdata : '0;

endmodule
`default_nettype wire
